// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Purpose  : Shared definitions for the UART IMEM loader: RX state encoding
//            and the baud divisor computation.
// Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Clocks per UART bit; integer division, caller guarantees result >= 4.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Purpose  : 8N1 UART receiver. Synchronizes rxd, detects start edges, samples
//            mid-bit and emits one-cycle byte_vld or frame_err pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  input  logic       rx_en,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int                 CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);

  logic             sync1_q;
  logic             rx_s_q;
  logic             rx_prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             vld_q, vld_d;
  logic             ferr_q, ferr_d;
  logic             start_edge;

  assign start_edge = rx_prev_q & ~rx_s_q;
  assign byte_vld   = vld_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

  // Two-stage synchronizer plus one history stage for falling-edge detection.
  // Reset to the idle-high line level so reset release never looks like a start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rxd;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Receiver state, baud counter, bit index and shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: mid-start check at DIV/2, then one sample every DIV clocks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_en && start_edge) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          vld_d   = rx_s_q;
          ferr_d  = ~rx_s_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disarming aborts any frame in flight.
    if (!rx_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      vld_d   = 1'b0;
      ferr_d  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_imem_loader
// Purpose  : Assembles little-endian UART bytes into 32-bit words and writes
//            them to IMEM. Optional running byte checksum is enabled by
//            defining UART_IMEM_LOADER_CKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 6,
  parameter int WORDS  = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  input  logic              load_en,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              frame_err,
  output logic [7:0]        cksum
);

  localparam int            DIV       = calc_div(CLK_HZ, BAUD);
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(WORDS - 1);

  logic              load_en_q;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;
  logic              load_rise;
  logic              rx_en;
  logic              accept;
  logic              byte_vld;
  logic [7:0]        byte_data;
  logic              frame_pulse;

  // A rising load_en re-arms even if the previous load had completed.
  assign load_rise = load_en & ~load_en_q;
  assign rx_en     = load_en & (~done_q | load_rise);
  assign accept    = byte_vld & rx_en;

  uart_rx_byte #(
    .DIV (DIV)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .rx_en     (rx_en),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .frame_err (frame_pulse)
  );

  // Assembler and status registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_en_q  <= 1'b0;
      byte_cnt_q <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      word_cnt_q <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      load_en_q  <= load_en;
      byte_cnt_q <= byte_cnt_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      word_cnt_q <= word_cnt_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  // Byte lane fill, write strobe, post-write address advance and load control.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    word_cnt_d = word_cnt_q;
    done_d     = done_q;
    ferr_d     = ferr_q;
    busy_d     = busy_q;
    if (accept) begin
      wdata_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
      byte_cnt_d = byte_cnt_q + 2'd1;
      we_d       = (byte_cnt_q == 2'd3);
      busy_d     = 1'b1;
    end
    if (we_q) begin
      waddr_d    = waddr_q + ADDR_W'(1);
      word_cnt_d = word_cnt_q + (ADDR_W + 1)'(1);
      byte_cnt_d = '0;
      if (word_cnt_q == LAST_WORD) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
    end
    if (frame_pulse && rx_en) ferr_d = 1'b1;
    if (!load_en) begin
      byte_cnt_d = '0;
      busy_d     = 1'b0;
    end
    if (load_rise) begin
      byte_cnt_d = '0;
      waddr_d    = '0;
      word_cnt_d = '0;
      done_d     = 1'b0;
      ferr_d     = 1'b0;
    end
  end

`ifdef UART_IMEM_LOADER_CKSUM_EN
  logic [7:0] cksum_q, cksum_d;

  // Running modulo-256 sum of accepted bytes, restarted on each new load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cksum_q <= '0;
    else       cksum_q <= cksum_d;
  end

  // Checksum next-value.
  always_comb begin
    cksum_d = cksum_q;
    if (accept)    cksum_d = cksum_q + byte_data;
    if (load_rise) cksum_d = '0;
  end

  assign cksum = cksum_q;
`else
  assign cksum = 8'd0;
`endif

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign word_cnt  = word_cnt_q;
  assign frame_err = ferr_q;

endmodule
`default_nettype wire

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
UART receiver plus word assembler that writes program words into the instruction memory the single-cycle CPU fetches from. It is the write side of the IMEM port that the CPU only reads. Lets a host download a program without rebuilding the bitstream. While loading, `busy` is high and the top level holds the CPU clock gated.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. DIV = CLK_HZ/BAUD (integer division, must be ≥ 4).
- ADDR_W, 6, IMEM word-address width.
- WORDS, 64, number of words per complete load. Must be ≤ 2^ADDR_W.

Ports:
- clk, in, 1: system clock.
- rstn, in, 1: reset, asynchronous, active-low.
- rxd, in, 1: UART line, idle high, asynchronous to clk.
- load_en, in, 1: level. High = loader armed (sw_i-driven).
- we, out, 1: one-cycle IMEM write strobe.
- waddr, out, ADDR_W: IMEM word address.
- wdata, out, 32: IMEM write data.
- busy, out, 1: load in progress.
- done, out, 1: WORDS words written. Sticky.
- word_cnt, out, ADDR_W+1: number of words written so far.
- frame_err, out, 1: sticky stop-bit error.
- cksum, out, 8: running byte checksum (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; internal FSMs in IDLE.
- rxd input:
  - Passes through a 2-FF synchronizer before use.
  - rx_s is the synchronized value; a start is the 1→0 transition of rx_s.
- RX FSM states: IDLE, START, DATA, STOP. Baud counter runs 0..DIV-1.
  - IDLE → START on a start edge, only while load_en=1 and done=0. Counter cleared.
  - START: sample rx_s at count DIV/2.
    - rx_s=1: false start, return to IDLE.
    - rx_s=0: counter reset, go to DATA.
  - DATA: sample at each count DIV-1. 8 bits, LSB first, bit index 0..7. After bit 7, go to STOP.
  - STOP: sample at count DIV-1.
    - rx_s=1: byte valid for one cycle (byte_vld).
    - rx_s=0: set frame_err and discard the byte.
    - Either way return to IDLE. A new start can be detected the following cycle.
- Word assembler:
  - Bytes arrive little-endian; the first byte goes to wdata[7:0].
  - A 2-bit byte counter tracks position in the word.
  - On the 4th valid byte:
    - we=1 for exactly one cycle; waddr and wdata are stable during that cycle.
    - Latency: we asserts on the cycle after the byte_vld of the 4th byte.
    - After the we cycle, waddr increments, word_cnt increments, and the byte counter resets.
  - waddr wraps is impossible: loading stops at WORDS.
- busy:
  - Set on the first valid byte while load_en=1.
  - Cleared when done rises or load_en falls.
- done: set on the cycle after the WORDS-th we. Further bytes are ignored.
- load_en falling mid-operation:
  - RX FSM goes to IDLE immediately.
  - Partial word and byte counter are discarded.
  - waddr, word_cnt, done and frame_err hold their values.
- load_en rising (0→1):
  - Clears waddr, word_cnt, done, frame_err, cksum and the byte counter.
  - A new load starts at address 0.
- A start edge in the same cycle as load_en rising is accepted (clears take priority for the registers they touch).
- rstn assertion at any time aborts everything. we must never glitch high during reset.

Optional Feature:
- Macro: UART_IMEM_LOADER_CKSUM_EN.
- Defined:
  - cksum = 8-bit modulo-256 sum of every valid byte of the current load.
  - Updated in the cycle after byte_vld; cleared on a load_en rise.
- Undefined: cksum is tied to 0 and no adder is instantiated.

Decomposition:
- Shared package (loader_pkg) holds:
  - RX state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - The DIV computation function.
- One natural sub-module: uart_rx_byte (synchronizer, RX FSM, byte_vld/byte/frame_err). The word assembler stays in uart_imem_loader.

Test Plan (CLK_HZ=16, BAUD=1, so DIV=16; WORDS=4 for sim):
1. Reset, then load_en=1 and send bytes 13 00 00 00 → one we pulse with waddr=0, wdata=32'h00000013. word_cnt=1, busy=1.
2. Send 16 bytes forming 00000013, 00100093, 00200113, 002081B3 → we at waddr 0,1,2,3 with those data. done=1, busy=0. A 17th byte produces no we.
3. 8-cycle low glitch on rxd in IDLE → no byte_vld, no state change.
4. Byte 0xA5 with stop bit 0 → frame_err=1, no byte counted. Next good bytes are still assembled.
5. Send 2 bytes, drop load_en, raise it again, send 4 bytes 01 02 03 04 → we at waddr 0 with wdata=32'h04030201.
6. With UART_IMEM_LOADER_CKSUM_EN, bytes FF 02 10 00 → cksum=8'h11. Without the macro → cksum=0.
